alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter DATA_W, default 32: operand, result and register width.
REQ-002 Parameter REG_AW, default 3: register address width; register file depth is 2**REG_AW = 8.
REQ-003 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 Port rst, input, 1: reset, synchronous, active-high.
REQ-005 Port instr_valid, input, 1: instruction offered.
REQ-006 Port instr_ready, output, 1: sequencer accepts an instruction this cycle.
REQ-007 Port instr, input, 12: [11:9] aop, [8:6] rd, [5:3] ra, [2:0] rb.
REQ-008 Port wr_en, input, 1: host register preload request.
REQ-009 Port wr_addr, input, REG_AW: preload address.
REQ-010 Port wr_data, input, DATA_W: preload data.
REQ-011 Port wr_ack, output, 1: one-cycle pulse confirming a preload.
REQ-012 Port aop, output, 3: operation code driven to the ALU.
REQ-013 Port r2, output, DATA_W: first ALU operand (register ra).
REQ-014 Port r3, output, DATA_W: second ALU operand (register rb).
REQ-015 Port r1, input, DATA_W: combinational ALU result.
REQ-016 Port res_valid, output, 1: one-cycle pulse on writeback.
REQ-017 Port res_addr, output, REG_AW: destination written (rd).
REQ-018 Port res_data, output, DATA_W: value written.
REQ-019 Port busy, output, 1: high in any state other than IDLE.

Function
REQ-020 FSM states SHALL be IDLE, READ, EXEC, WB; each non-IDLE state lasts exactly one cycle.
REQ-021 instr_ready SHALL equal (state==IDLE) && !wr_en; a transfer occurs when instr_valid && instr_ready.
REQ-022 On transfer, fields SHALL be captured and state SHALL go IDLE->READ.
REQ-023 In READ, r2/r3 SHALL be registered from regfile[ra]/regfile[rb] and aop from the captured field; state->EXEC.
REQ-024 In EXEC, aop/r2/r3 SHALL be stable and r1 SHALL be sampled at the cycle end; state->WB.
REQ-025 In WB, regfile[rd] SHALL be written with the sampled r1, res_valid=1, res_addr=rd, res_data=sampled r1; state->IDLE.
REQ-026 Latency: transfer in cycle N -> res_valid in cycle N+3; next transfer no earlier than N+4 (max throughput 1 per 4 cycles).
REQ-027 aop, r2, r3 SHALL hold their last values in IDLE, WB and READ until reloaded.
REQ-028 Preload: wr_en in IDLE SHALL write regfile[wr_addr]=wr_data and pulse wr_ack next cycle; preload has priority over instruction accept.
REQ-029 wr_en outside IDLE SHALL be ignored (no write, no wr_ack); the host retries.
REQ-030 rd equal to ra or rb SHALL read the old value and write the new value (no hazard; operations strictly serialized).
REQ-031 All 8 registers, including address 0, SHALL be general-purpose and writable.
REQ-032 Result width: r1 SHALL be written unmodified; no sign or carry handling in this block.

Reset
REQ-033 rst SHALL force state=IDLE, all registers=0, aop=0, r2=r3=0, res_valid=0, res_addr=0, res_data=0, wr_ack=0.
REQ-034 rst in READ/EXEC/WB SHALL abort the operation with no writeback and no res_valid.
REQ-035 instr_ready SHALL be 0 during the rst cycle and 1 (if wr_en=0) the cycle after.

Structure
REQ-036 A shared package SHALL hold the FSM state enum, the aop encoding constants (MOV=0, NOT=1, ADD=2, SUB=3, OR=4, AND=5, XOR=6, SLT=7) and the instr field positions.
REQ-037 The register file SHALL be a sub-module reg_file8x32: two combinational read ports, one synchronous write port, synchronous clear on rst.
REQ-038 The write port mux (preload vs WB) SHALL live in alu_sequencer; both can never occur in the same cycle by REQ-028/029.

Verification (bench connects the existing ALU between aop/r2/r3 and r1)
REQ-039 Preload R1=5, R2=3; ADD rd=3 ra=1 rb=2 -> EXEC shows aop=2, r2=5, r3=3; res_valid at N+3 with res_addr=3, res_data=8.
REQ-040 instr_valid held high with two instructions -> second transfer exactly 4 cycles after first; instr_ready low in between.
REQ-041 R1=0xFFFFFFFF; NOT rd=1 ra=1 -> R1=0; then SUB rd=4 ra=1 rb=2 (R2=1) -> res_data=0xFFFFFFFF.
REQ-042 wr_en and instr_valid together in IDLE -> preload done, wr_ack next cycle, instruction accepted the following cycle.
REQ-043 rst asserted during EXEC -> no res_valid, all registers read 0 afterward, state IDLE.
REQ-044 SLT with R1=3, R2=5 -> res_data=1; swapped operands -> res_data=0.

Source files
------------

// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer: FSM states, ALU operation codes,
// and the layout of the 12-bit instruction word.
package alu_sequencer_pkg;

  // Sequencer states; every state except IDLE lasts exactly one cycle.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } seq_state_t;

  // Operation codes understood by the external ALU.
  localparam logic [2:0] AOP_MOV = 3'd0;
  localparam logic [2:0] AOP_NOT = 3'd1;
  localparam logic [2:0] AOP_ADD = 3'd2;
  localparam logic [2:0] AOP_SUB = 3'd3;
  localparam logic [2:0] AOP_OR  = 3'd4;
  localparam logic [2:0] AOP_AND = 3'd5;
  localparam logic [2:0] AOP_XOR = 3'd6;
  localparam logic [2:0] AOP_SLT = 3'd7;

  // Instruction word layout: [11:9] aop, [8:6] rd, [5:3] ra, [2:0] rb.
  localparam int INSTR_W = 12;
  localparam int FIELD_W = 3;
  localparam int AOP_LSB = 9;
  localparam int RD_LSB  = 6;
  localparam int RA_LSB  = 3;
  localparam int RB_LSB  = 0;

  // Decoded instruction fields.
  typedef struct packed {
    logic [FIELD_W-1:0] aop;
    logic [FIELD_W-1:0] rd;
    logic [FIELD_W-1:0] ra;
    logic [FIELD_W-1:0] rb;
  } instr_t;

  // Split a raw instruction word into its fields.
  function automatic instr_t decode_instr(input logic [INSTR_W-1:0] raw);
    instr_t f;
    f.aop = raw[AOP_LSB +: FIELD_W];
    f.rd  = raw[RD_LSB  +: FIELD_W];
    f.ra  = raw[RA_LSB  +: FIELD_W];
    f.rb  = raw[RB_LSB  +: FIELD_W];
    return f;
  endfunction

endpackage

// File: rtl/alu_sequencer_reg_file8x32.sv
// General-purpose register file for the ALU sequencer: two combinational
// read ports, one synchronous write port, synchronous clear on rst.
module reg_file8x32 #(
  parameter int DATA_W = 32,
  parameter int AW     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     ra_addr,
  output logic [DATA_W-1:0] ra_data,
  input  logic [AW-1:0]     rb_addr,
  output logic [DATA_W-1:0] rb_data,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata
);

  localparam int DEPTH = 2 ** AW;

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port with synchronous clear of every entry.
  // NOTE: clearing the whole array on reset forces flops instead of a RAM
  // macro; acceptable here because the file is only eight entries deep.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Combinational read ports; a same-cycle write is seen on the next cycle.
  assign ra_data = mem[ra_addr];
  assign rb_data = mem[rb_addr];

endmodule

// File: rtl/alu_sequencer.sv
// ALU sequencer: accepts one instruction at a time, reads operands from the
// register file, presents them to an external combinational ALU, and writes
// the ALU result back. Host preloads share the register write port.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [11:0]       instr,
  input  logic              wr_en,
  input  logic [REG_AW-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic [2:0]        aop,
  output logic [DATA_W-1:0] r2,
  output logic [DATA_W-1:0] r3,
  input  logic [DATA_W-1:0] r1,
  output logic              res_valid,
  output logic [REG_AW-1:0] res_addr,
  output logic [DATA_W-1:0] res_data,
  output logic              busy
);

  seq_state_t state_q;
  seq_state_t state_d;

  instr_t            cur_q;      // instruction captured on transfer
  logic [2:0]        aop_q;
  logic [DATA_W-1:0] r2_q;
  logic [DATA_W-1:0] r3_q;
  logic [DATA_W-1:0] res_q;      // ALU result sampled at the end of EXEC
  logic              wr_ack_q;

  logic              xfer;
  logic              preload;
  logic              wb_we;

  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] rf_ra_data;
  logic [DATA_W-1:0] rf_rb_data;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and per-state control strobes.
  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    busy        = 1'b1;
    xfer        = 1'b0;
    preload     = 1'b0;
    wb_we       = 1'b0;
    res_valid   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        busy        = 1'b0;
        // A preload takes the cycle; the instruction waits for the next one.
        preload     = wr_en && !rst;
        instr_ready = !wr_en && !rst;
        xfer        = instr_valid && instr_ready;
        if (xfer) begin
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        state_d = ST_WB;
      end
      ST_WB: begin
        // A reset landing on the writeback cycle aborts it entirely.
        wb_we     = !rst;
        res_valid = !rst;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath: instruction capture, operand registers, result sample, ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q    <= '0;
      aop_q    <= '0;
      r2_q     <= '0;
      r3_q     <= '0;
      res_q    <= '0;
      wr_ack_q <= 1'b0;
    end else begin
      wr_ack_q <= preload;
      if (xfer) begin
        cur_q <= decode_instr(instr);
      end
      // Operands are loaded once in READ and then held until the next READ.
      if (state_q == ST_READ) begin
        aop_q <= cur_q.aop;
        r2_q  <= rf_ra_data;
        r3_q  <= rf_rb_data;
      end
      if (state_q == ST_EXEC) begin
        res_q <= r1;
      end
    end
  end

  // Register write port: preload only in IDLE, writeback only in WB, so the
  // two sources are mutually exclusive and a plain mux suffices.
  always_comb begin
    rf_we    = preload || wb_we;
    rf_waddr = wr_addr;
    rf_wdata = wr_data;
    if (wb_we) begin
      rf_waddr = cur_q.rd;
      rf_wdata = res_q;
    end
  end

  reg_file8x32 #(
    .DATA_W (DATA_W),
    .AW     (REG_AW)
  ) u_reg_file (
    .clk     (clk),
    .rst     (rst),
    .ra_addr (cur_q.ra),
    .ra_data (rf_ra_data),
    .rb_addr (cur_q.rb),
    .rb_data (rf_rb_data),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata)
  );

  assign aop      = aop_q;
  assign r2       = r2_q;
  assign r3       = r3_q;
  assign res_addr = cur_q.rd;
  assign res_data = res_q;
  assign wr_ack   = wr_ack_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: a reference ALU sits between
// aop/r2/r3 and r1, a transaction-level model predicts every output each
// cycle, and directed scenarios pin the model with hand-computed values.
module tb_alu_sequencer;

  localparam logic [2:0] OP_MOV = 3'd0, OP_NOT = 3'd1, OP_ADD = 3'd2, OP_SUB = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4, OP_AND = 3'd5, OP_XOR = 3'd6, OP_SLT = 3'd7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [11:0] instr = '0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        wr_ack;
  logic [2:0]  aop;
  logic [31:0] r2, r3, r1;
  logic        res_valid;
  logic [2:0]  res_addr;
  logic [31:0] res_data;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.DATA_W(32), .REG_AW(3)) dut (
    .clk (clk), .rst (rst),
    .instr_valid (instr_valid), .instr_ready (instr_ready), .instr (instr),
    .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data), .wr_ack (wr_ack),
    .aop (aop), .r2 (r2), .r3 (r3), .r1 (r1),
    .res_valid (res_valid), .res_addr (res_addr), .res_data (res_data),
    .busy (busy)
  );

  // Reference ALU.
  function automatic logic [31:0] alu_fn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      OP_MOV:  return a;
      OP_NOT:  return ~a;
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_OR:   return a | b;
      OP_AND:  return a & b;
      OP_XOR:  return a ^ b;
      default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    endcase
  endfunction

  assign r1 = alu_fn(aop, r2, r3);

  function automatic logic [11:0] mk(input logic [2:0] op, input logic [2:0] rd,
                                     input logic [2:0] ra, input logic [2:0] rb);
    return {op, rd, ra, rb};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction-level model: one operation in flight, results timed from
  // the accept cycle, register contents kept as a plain array.
  logic [31:0] m_regs [8];
  int          free_cyc, exec_cyc, wb_cyc;
  logic [2:0]  p_aop, p_rd;
  logic [31:0] p_a, p_b, p_res;
  logic [2:0]  e_aop;
  logic [31:0] e_r2, e_r3;
  bit          ack_due, model_on, just_reset;

  initial begin : compare
    bit exp_busy;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        check("ready_in_rst", instr_ready, 0);
        check("res_valid_in_rst", res_valid, 0);
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
        free_cyc = 0; exec_cyc = -1; wb_cyc = -1;
        e_aop = '0; e_r2 = '0; e_r3 = '0;
        ack_due = 0; model_on = 1; just_reset = 1;
      end else if (model_on) begin
        if (cyc == exec_cyc) begin
          e_aop = p_aop; e_r2 = p_a; e_r3 = p_b;
        end
        exp_busy = (cyc < free_cyc);
        check("busy", busy, exp_busy);
        check("instr_ready", instr_ready, !exp_busy && !wr_en);
        check("wr_ack", wr_ack, ack_due);
        check("aop", aop, e_aop);
        check("r2", r2, e_r2);
        check("r3", r3, e_r3);
        check("res_valid", res_valid, cyc == wb_cyc);
        if (cyc == wb_cyc) begin
          check("res_addr", res_addr, p_rd);
          check("res_data", res_data, p_res);
        end
        if (just_reset) begin
          check("res_addr_after_rst", res_addr, 0);
          check("res_data_after_rst", res_data, 0);
          just_reset = 0;
        end
        ack_due = 0;
        if (cyc == wb_cyc) m_regs[p_rd] = p_res;
        if (!exp_busy && wr_en) begin
          m_regs[wr_addr] = wr_data;
          ack_due = 1;
        end else if (!exp_busy && instr_valid) begin
          p_aop = instr[11:9]; p_rd = instr[8:6];
          p_a = m_regs[instr[5:3]]; p_b = m_regs[instr[2:0]];
          p_res = alu_fn(p_aop, p_a, p_b);
          exec_cyc = cyc + 2; wb_cyc = cyc + 3; free_cyc = cyc + 4;
        end
      end
    end
  end

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic preload(input logic [2:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  // Offer one instruction, wait for its writeback; reports result, the
  // operands seen in EXEC and the latency from accept to res_valid.
  task automatic run_op(input logic [11:0] ins, output logic [31:0] data,
                        output logic [2:0] addr, output logic [2:0] x_aop,
                        output logic [31:0] x_r2, output logic [31:0] x_r3,
                        output int lat);
    bit got;
    data = '0; addr = '0; x_aop = '0; x_r2 = '0; x_r3 = '0; lat = 0;
    @(posedge clk); #1;
    instr = ins; instr_valid = 1'b1;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      sample();
      if (instr_ready) begin got = 1; break; end
    end
    @(posedge clk); #1;
    instr_valid = 1'b0;
    if (!got) begin
      total++; bad++;
      $display("FAIL accept_timeout: instr %h never accepted", ins);
      return;
    end
    for (int i = 1; i <= 8; i++) begin
      sample();
      if (i == 2) begin x_aop = aop; x_r2 = r2; x_r3 = r3; end
      if (res_valid) begin lat = i; data = res_data; addr = res_addr; break; end
    end
    if (lat == 0) begin
      total++; bad++;
      $display("FAIL result_timeout: instr %h produced no res_valid", ins);
    end
  endtask

  task automatic op_check(input string name, input logic [11:0] ins, input logic [31:0] exp_data);
    logic [31:0] d, a2, a3;
    logic [2:0]  ad, op;
    int          lat;
    run_op(ins, d, ad, op, a2, a3, lat);
    check({name, "_data"}, d, exp_data);
    check({name, "_addr"}, ad, ins[8:6]);
    check({name, "_lat"}, lat, 3);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [31:0] d, a2, a3, first_res;
    logic [2:0]  ad, op;
    int          lat, a1c, a2c, acks, rv;
    bit          got;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    sample();
    check("rst_ready", instr_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_aop", aop, 0);
    check("rst_r2", r2, 0);
    check("rst_wr_ack", wr_ack, 0);

    // ADD with operand visibility in EXEC.
    preload(3'd1, 32'd5);
    preload(3'd2, 32'd3);
    run_op(mk(OP_ADD, 3'd3, 3'd1, 3'd2), d, ad, op, a2, a3, lat);
    check("add_exec_aop", op, 2);
    check("add_exec_r2", a2, 5);
    check("add_exec_r3", a3, 3);
    check("add_data", d, 8);
    check("add_addr", ad, 3);
    check("add_lat", lat, 3);

    // NOT then SUB wrap-around.
    preload(3'd1, 32'hFFFF_FFFF);
    op_check("not", mk(OP_NOT, 3'd1, 3'd1, 3'd0), 32'h0);
    preload(3'd2, 32'd1);
    op_check("sub", mk(OP_SUB, 3'd4, 3'd1, 3'd2), 32'hFFFF_FFFF);

    // SLT both ways; R0 is an ordinary register.
    preload(3'd1, 32'd3);
    preload(3'd2, 32'd5);
    op_check("slt_lt", mk(OP_SLT, 3'd0, 3'd1, 3'd2), 32'd1);
    op_check("mov_r0", mk(OP_MOV, 3'd5, 3'd0, 3'd0), 32'd1);
    op_check("slt_ge", mk(OP_SLT, 3'd0, 3'd2, 3'd1), 32'd0);

    // Logic ops and rd aliasing ra/rb.
    preload(3'd6, 32'hF0F0_1234);
    preload(3'd7, 32'h0FF0_00FF);
    op_check("or",  mk(OP_OR,  3'd3, 3'd6, 3'd7), 32'hFFF0_12FF);
    op_check("and", mk(OP_AND, 3'd3, 3'd6, 3'd7), 32'h00F0_0034);
    op_check("xor", mk(OP_XOR, 3'd3, 3'd6, 3'd7), 32'hFF00_12CB);
    op_check("add_alias", mk(OP_ADD, 3'd6, 3'd6, 3'd6), 32'hE1E0_2468);
    op_check("mov_alias", mk(OP_MOV, 3'd1, 3'd6, 3'd0), 32'hE1E0_2468);

    // Back-to-back: instr_valid held high across two instructions.
    @(posedge clk); #1;
    instr = mk(OP_MOV, 3'd2, 3'd7, 3'd0); instr_valid = 1'b1;
    sample();
    a1c = cyc;
    check("b2b_first_ready", instr_ready, 1);
    @(posedge clk); #1;
    instr = mk(OP_XOR, 3'd3, 3'd7, 3'd7);
    got = 0; first_res = '0; a2c = 0;
    for (int i = 0; i < 10; i++) begin
      sample();
      if (res_valid) first_res = res_data;
      if (instr_ready) begin got = 1; a2c = cyc; break; end
    end
    @(posedge clk); #1;
    instr_valid = 1'b0;
    check("b2b_gap", a2c - a1c, 4);
    check("b2b_first_res", first_res, 32'h0FF0_00FF);
    repeat (2) sample();
    sample();
    check("b2b_second_valid", res_valid, 1);
    check("b2b_second_res", res_data, 32'h0);

    // Preload and instruction offered together in IDLE.
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 32'h1234_5678;
    instr = mk(OP_MOV, 3'd6, 3'd5, 3'd0); instr_valid = 1'b1;
    sample();
    check("pre_prio_ready", instr_ready, 0);
    @(posedge clk); #1;
    wr_en = 1'b0;
    sample();
    check("pre_prio_ack", wr_ack, 1);
    check("pre_prio_accept", instr_ready, 1);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    repeat (2) sample();
    sample();
    check("pre_prio_valid", res_valid, 1);
    check("pre_prio_res", res_data, 32'h1234_5678);

    // Preload attempted while busy is dropped.
    preload(3'd3, 32'hA5A5_A5A5);
    @(posedge clk); #1;
    instr = mk(OP_MOV, 3'd0, 3'd3, 3'd0); instr_valid = 1'b1;
    sample();
    @(posedge clk); #1;
    instr_valid = 1'b0;
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 32'hDEAD_BEEF;
    acks = 0;
    sample(); if (wr_ack) acks++;
    @(posedge clk); #1;
    sample(); if (wr_ack) acks++;
    @(posedge clk); #1;
    wr_en = 1'b0;
    sample(); if (wr_ack) acks++;
    sample(); if (wr_ack) acks++;
    check("busy_wr_no_ack", acks, 0);
    op_check("busy_wr_ignored", mk(OP_MOV, 3'd1, 3'd3, 3'd0), 32'hA5A5_A5A5);

    // Reset during EXEC aborts the operation and clears the registers.
    @(posedge clk); #1;
    instr = mk(OP_ADD, 3'd7, 3'd6, 3'd6); instr_valid = 1'b1;
    sample();
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    sample();
    check("rst_exec_no_valid", res_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    rv = 0;
    for (int i = 0; i < 4; i++) begin
      sample();
      if (res_valid) rv++;
    end
    check("abort_no_res_valid", rv, 0);
    check("abort_idle", busy, 0);
    check("abort_ready", instr_ready, 1);
    check("abort_r3", r3, 0);
    for (int i = 0; i < 8; i++) begin
      op_check($sformatf("cleared_r%0d", i), mk(OP_MOV, 3'(i), 3'(i), 3'd0), 32'h0);
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
